// File: rtl/prbs_galois_link.sv
// Galois PRBS link-test block: generator with corruption injection feeding a
// self-synchronising checker with hysteretic lock and saturating error count.
module prbs_galois_link #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] POLY         = WIDTH'('hB8),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1),
  parameter int unsigned      LOCK_CNT     = 5,
  parameter int unsigned      UNLOCK_CNT   = 3,
  parameter int unsigned      ERR_W        = 16
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_soft_reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_corrupt,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_lock,
  output logic [ERR_W-1:0] o_err_count
);

  localparam int unsigned      MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned      MISS_W  = $clog2(UNLOCK_CNT + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

  // Galois next-state: right shift, fold in taps when the LSB falls out
  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? POLY : '0);
  endfunction

  logic [WIDTH-1:0]   r_gen;
  logic [WIDTH-1:0]   r_data;
  logic               r_valid;
  state_t             r_state;
  logic [WIDTH-1:0]   r_chk;
  logic [MATCH_W-1:0] r_match;
  logic [MISS_W-1:0]  r_miss;
  logic               r_lock;
  logic [ERR_W-1:0]   r_err;

  state_t             w_state_nxt;
  logic [WIDTH-1:0]   w_chk_nxt;
  logic [MATCH_W-1:0] w_match_nxt;
  logic [MISS_W-1:0]  w_miss_nxt;
  logic               w_lock_nxt;
  logic [ERR_W-1:0]   w_err_nxt;
  logic [WIDTH-1:0]   w_seed;
  logic [WIDTH-1:0]   w_corrupt_mask;
  logic               w_rx_match;

  // An all-zero seed would lock the LFSR up, so substitute the default
  assign w_seed         = (i_seed == '0) ? DEFAULT_SEED : i_seed;
  assign w_corrupt_mask = {{(WIDTH-1){1'b0}}, i_corrupt};
  assign w_rx_match     = (r_data == r_chk);

  // Generator: emits one word per valid cycle, reloads on soft reset
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_gen   <= DEFAULT_SEED;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_soft_reset) begin
      r_gen   <= w_seed;
      r_valid <= 1'b0;
    end else if (i_valid) begin
      r_data  <= r_gen ^ w_corrupt_mask;
      r_valid <= 1'b1;
      r_gen   <= nxt(r_gen);
    end else begin
      r_valid <= 1'b0;
    end
  end

  // Checker state register
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_UNLOCKED;
      r_chk   <= '0;
      r_match <= '0;
      r_miss  <= '0;
      r_lock  <= 1'b0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_chk   <= w_chk_nxt;
      r_match <= w_match_nxt;
      r_miss  <= w_miss_nxt;
      r_lock  <= w_lock_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Checker next-state: re-seed from the line while unlocked, flywheel once locked
  always_comb begin
    w_state_nxt = r_state;
    w_chk_nxt   = r_chk;
    w_match_nxt = r_match;
    w_miss_nxt  = r_miss;
    w_lock_nxt  = r_lock;
    w_err_nxt   = r_err;
    if (i_soft_reset) begin
      w_state_nxt = ST_UNLOCKED;
      w_chk_nxt   = '0;
      w_match_nxt = '0;
      w_miss_nxt  = '0;
      w_lock_nxt  = 1'b0;
      w_err_nxt   = '0;
    end else if (r_valid) begin
      case (r_state)
        ST_UNLOCKED: begin
          w_chk_nxt = nxt(r_data);
          if (w_rx_match) begin
            if (r_match == MATCH_W'(LOCK_CNT - 1)) begin
              w_state_nxt = ST_LOCKED;
              w_lock_nxt  = 1'b1;
              w_miss_nxt  = '0;
              w_match_nxt = '0;
            end else begin
              w_match_nxt = MATCH_W'(r_match + 1'b1);
            end
          end else begin
            w_match_nxt = '0;
          end
        end
        ST_LOCKED: begin
          w_chk_nxt = nxt(r_chk);
          if (w_rx_match) begin
            w_miss_nxt = '0;
          end else begin
            if (r_err != ERR_MAX) w_err_nxt = ERR_W'(r_err + 1'b1);
            if (r_miss == MISS_W'(UNLOCK_CNT - 1)) begin
              w_state_nxt = ST_UNLOCKED;
              w_lock_nxt  = 1'b0;
              w_match_nxt = '0;
              w_miss_nxt  = '0;
            end else begin
              w_miss_nxt = MISS_W'(r_miss + 1'b1);
            end
          end
        end
        default: w_state_nxt = ST_UNLOCKED;
      endcase
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_lock      = r_lock;
  assign o_err_count = r_err;

endmodule

// File: tb/tb_prbs_galois_link.sv
// Directed bench for prbs_galois_link with default parameters.
module tb_prbs_galois_link;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        soft_reset = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  seed = 8'h00;
  logic        corrupt = 1'b0;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_lock;
  logic [15:0] o_err_count;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] exp_gen;   // next word the generator should emit
  logic [7:0] last_data; // last word emitted

  prbs_galois_link dut (
    .clk          (clk),
    .i_rst        (rst),
    .i_soft_reset (soft_reset),
    .i_valid      (valid),
    .i_seed       (seed),
    .i_corrupt    (corrupt),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_lock       (o_lock),
    .o_err_count  (o_err_count)
  );

  always #5 clk = ~clk;

  // Reference LFSR step with tap mask B8
  function automatic logic [7:0] ref_nxt(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #($urandom_range(2000, 1));
    n_total++;
    if ({o_valid, o_data, o_lock, o_err_count} !== 26'd0)
      $display("FAIL reset_hold: got v=%b d=%h l=%b e=%0d want all 0", o_valid, o_data, o_lock, o_err_count);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_total++;
      if ({o_valid, o_data, o_lock, o_err_count} !== 26'd0)
        $display("FAIL reset_idle[%0d]: got v=%b d=%h l=%b e=%0d want all 0", i, o_valid, o_data, o_lock, o_err_count);
      else n_pass++;
    end
  endtask

  task automatic test_seq_lock();
    logic [7:0] exp_tab [8];
    exp_tab = '{8'hAA, 8'h55, 8'h92, 8'h49, 8'h9C, 8'h4E, 8'h27, 8'hAB};
    seed = 8'hAA;
    soft_reset = 1'b1;
    valid = 1'b0;
    step();
    n_total++;
    if (o_valid !== 1'b0) $display("FAIL seq_softrst_valid: got %b want 0", o_valid);
    else n_pass++;
    soft_reset = 1'b0;
    valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      n_total++;
      if ({o_valid, o_data, o_lock, o_err_count} !== {1'b1, exp_tab[k], (k >= 6), 16'd0})
        $display("FAIL seq_word[%0d]: got v=%b d=%h l=%b e=%0d want v=1 d=%h l=%b e=0",
                 k, o_valid, o_data, o_lock, o_err_count, exp_tab[k], (k >= 6));
      else n_pass++;
    end
    last_data = 8'hAB;
    exp_gen   = 8'hED;
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 100; i++) begin
      logic v;
      logic [7:0] exp_d;
      v = 1'($urandom_range(1, 0));
      valid = v;
      step();
      if (v) begin
        exp_d     = exp_gen;
        last_data = exp_gen;
        exp_gen   = ref_nxt(exp_gen);
      end else begin
        exp_d = last_data;
      end
      n_total++;
      if ({o_valid, o_data, o_lock, o_err_count} !== {v, exp_d, 1'b1, 16'd0})
        $display("FAIL gaps[%0d]: got v=%b d=%h l=%b e=%0d want v=%b d=%h l=1 e=0",
                 i, o_valid, o_data, o_lock, o_err_count, v, exp_d);
      else n_pass++;
    end
  endtask

  task automatic test_corrupt_unlock();
    logic [15:0] exp_err [4];
    logic        exp_lk  [4];
    exp_err = '{16'd0, 16'd1, 16'd2, 16'd3};
    exp_lk  = '{1'b1, 1'b1, 1'b1, 1'b0};
    valid   = 1'b1;
    corrupt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_total++;
      if ({o_valid, o_data, o_lock, o_err_count} !== {1'b1, exp_gen ^ 8'h01, exp_lk[k], exp_err[k]})
        $display("FAIL corrupt[%0d]: got v=%b d=%h l=%b e=%0d want v=1 d=%h l=%b e=%0d",
                 k, o_valid, o_data, o_lock, o_err_count, exp_gen ^ 8'h01, exp_lk[k], exp_err[k]);
      else n_pass++;
      last_data = exp_gen ^ 8'h01;
      exp_gen   = ref_nxt(exp_gen);
    end
    corrupt = 1'b0;
  endtask

  task automatic test_relock();
    int lock_step = 0;
    valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_total++;
      if (o_data !== exp_gen) $display("FAIL relock_data[%0d]: got %h want %h", k, o_data, exp_gen);
      else n_pass++;
      last_data = exp_gen;
      exp_gen   = ref_nxt(exp_gen);
      if (o_lock === 1'b1 && lock_step == 0) lock_step = k;
    end
    n_total++;
    if (lock_step != 7) $display("FAIL relock_step: got %0d want 7 (0 means never)", lock_step);
    else n_pass++;
    n_total++;
    if (o_err_count !== 16'd3) $display("FAIL relock_err_kept: got %0d want 3", o_err_count);
    else n_pass++;
  endtask

  task automatic test_zero_seed_soft_reset();
    logic [7:0] exp_tab [7];
    exp_tab = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1};
    n_total++;
    if ({o_lock, o_err_count} !== {1'b1, 16'd3})
      $display("FAIL sr_precond: got l=%b e=%0d want l=1 e=3", o_lock, o_err_count);
    else n_pass++;
    seed = 8'h00;
    soft_reset = 1'b1;
    valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_total++;
      if ({o_valid, o_lock, o_err_count} !== 18'd0)
        $display("FAIL sr_hold[%0d]: got v=%b l=%b e=%0d want all 0", k, o_valid, o_lock, o_err_count);
      else n_pass++;
    end
    soft_reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      n_total++;
      if ({o_valid, o_data, o_lock, o_err_count} !== {1'b1, exp_tab[k], (k >= 6), 16'd0})
        $display("FAIL zseed_word[%0d]: got v=%b d=%h l=%b e=%0d want v=1 d=%h l=%b e=0",
                 k, o_valid, o_data, o_lock, o_err_count, exp_tab[k], (k >= 6));
      else n_pass++;
    end
    valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_seq_lock();
    test_gaps();
    test_corrupt_unlock();
    test_relock();
    test_zero_seed_soft_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prbs_galois_link.md
Name: prbs_galois_link

Overview:
- Parametrised successor to the 8-bit Galois LFSR generator/checker pair.
- Contains:
  - a WIDTH-bit Galois PRBS generator with a programmable polynomial;
  - a corruption-injection point on the link word;
  - a self-synchronising checker with hysteretic lock/unlock and a saturating error counter.
- Used as the link-test block ahead of the Ethernet datapath.

Parameters:
- WIDTH, 8, LFSR and link word width (at least 4).
- POLY, 8'hB8, Galois tap mask, applied on right shift when the LSB is 1.
- DEFAULT_SEED, 8'h01, seed used on i_rst, and substituted whenever the requested seed is all-zero. Must be non-zero.
- LOCK_CNT, 5, consecutive matching words needed to declare lock (at least 1).
- UNLOCK_CNT, 3, consecutive mismatching words needed to drop lock (at least 1).
- ERR_W, 16, error counter width.

Ports:
- clk, in, 1, system clock; all logic is on the rising edge.
- i_rst, in, 1, asynchronous active-high reset.
- i_soft_reset, in, 1, synchronous; reloads the generator from i_seed and resets the checker.
- i_valid, in, 1, advance enable for the generator; one word per cycle when high.
- i_seed, in, WIDTH, seed loaded on i_soft_reset.
- i_corrupt, in, 1, when high, XORs bit 0 of every link word sent that cycle.
- o_data, out, WIDTH, registered link word (after corruption).
- o_valid, out, 1, qualifies o_data.
- o_lock, out, 1, checker lock status.
- o_err_count, out, ERR_W, saturating count of mismatches seen while locked.

Behaviour:
- Clock and reset: one clock, clk. i_rst is asynchronous and active-high.
- On i_rst:
  - gen_state = DEFAULT_SEED, chk_state = 0;
  - o_data = 0, o_valid = 0, o_lock = 0, o_err_count = 0;
  - match_cnt = 0, miss_cnt = 0;
  - FSM = UNLOCKED.
- Next-state function: nxt(s) = (s >> 1) ^ (s[0] ? POLY : 0).
- Generator, per cycle:
  - if i_valid: o_data <= gen_state ^ {0, i_corrupt}, o_valid <= 1, gen_state <= nxt(gen_state);
  - else o_valid <= 0, with o_data and gen_state held.
- Generator latency: one cycle from i_valid to o_valid.
- Soft reset:
  - i_soft_reset has priority over i_valid.
  - gen_state <= (i_seed == 0) ? DEFAULT_SEED : i_seed.
  - o_valid <= 0, FSM <= UNLOCKED, counters cleared, o_err_count cleared, o_lock <= 0.
  - If held for several cycles, the reload repeats each cycle; generation resumes on the first cycle with i_soft_reset low.
- Checker operates only on cycles where o_valid = 1. The received word is rx = o_data. A match means rx == chk_state.
- FSM state UNLOCKED:
  - match: match_cnt++ and chk_state <= nxt(rx).
  - mismatch: match_cnt <= 0 and chk_state <= nxt(rx) (re-seed from the line).
  - When a match brings match_cnt to LOCK_CNT: FSM <= LOCKED, o_lock <= 1 at the same edge, miss_cnt <= 0.
- FSM state LOCKED (flywheel):
  - chk_state <= nxt(chk_state) on every received word; there is no re-seeding.
  - match: miss_cnt <= 0.
  - mismatch: miss_cnt++ and o_err_count++, saturating at 2^ERR_W - 1.
  - When a mismatch brings miss_cnt to UNLOCK_CNT: FSM <= UNLOCKED, o_lock <= 0, match_cnt <= 0.
- o_err_count is not cleared on unlock; only i_rst and i_soft_reset clear it.
- The first word after any reset compares against chk_state = 0 and is a mismatch unless rx = 0. The checker therefore self-seeds, and lock is asserted on the (LOCK_CNT+1)th valid word.
- i_valid gaps: generator and checker both freeze, so no mismatch is caused.
- A corrupt word in UNLOCKED re-seeds the checker from a bad value. This costs up to two further mismatches, and lock is then re-acquired after LOCK_CNT matches.
- i_corrupt held high: every word has bit 0 flipped. A flipped sequence is not a valid PRBS sequence under nxt, so lock is never reached.
- An all-zero i_seed is never loaded.
- The design must be width-generic; no hard-coded 8-bit constants.

Test Plan:
1. i_rst pulse of random length (1-2000 ns), then i_valid = 0 -> all outputs 0 and o_lock = 0 throughout.
2. i_seed = 8'hAA, i_soft_reset for 1 cycle, then i_valid = 1 continuously -> o_data = AA, 55, 92, 49, 9C, ...; o_lock rises on the edge of the 6th valid word (LOCK_CNT = 5); o_err_count = 0.
3. Random i_valid (100 cycles, about 50% duty) after lock -> o_lock stays 1, o_err_count = 0, o_data sequence identical to scenario 2 with gaps.
4. Locked, then i_corrupt = 1 for 2 valid words -> o_err_count = 2, o_lock stays 1. Then i_corrupt = 1 continuously -> o_lock falls on the 3rd consecutive mismatch, and o_err_count = 3 at unlock.
5. After scenario 4, i_corrupt = 0 -> o_lock re-asserts within LOCK_CNT + 3 valid words; o_err_count is retained.
6. i_seed = 0 with soft reset -> first o_data = DEFAULT_SEED (8'h01). i_soft_reset during lock -> o_lock = 0 and o_err_count = 0 on the next edge.
